// File: rtl/fifo_sync_prog.sv
// Single-clock show-ahead FIFO with arbitrary depth, exact fill level and programmable almost flags.
// Define FIFO_SYNC_PROG_ERR_EN to build the sticky overflow/underflow flags.
module fifo_sync_prog #(
    parameter int Depth = 8,
    parameter int Width = 8,
    localparam int AW = $clog2(Depth),
    localparam int LW = $clog2(Depth + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [Width-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [LW-1:0]    i_afull_thr,
    input  logic [LW-1:0]    i_aempty_thr,
    input  logic             i_err_clr,
    output logic [Width-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic [LW-1:0]    o_level,
    output logic             o_overflow,
    output logic             o_underflow
);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, empty_q, afull_q, aempty_q;
    logic             wr_acc, rd_acc;

    // Accepts look only at registered full/empty, so there is no pass-through.
    assign wr_acc = i_wr_en & ~full_q;
    assign rd_acc = i_rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_acc)
            wr_ptr_d = (wr_ptr_q == AW'(Depth - 1)) ? '0 : wr_ptr_q + AW'(1);
        if (rd_acc)
            rd_ptr_d = (rd_ptr_q == AW'(Depth - 1)) ? '0 : rd_ptr_q + AW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == LW'(Depth));
            empty_q  <= (level_d == '0);
            afull_q  <= (level_d >= i_afull_thr);
            aempty_q <= (level_d <= i_aempty_thr);
        end
    end

    // Storage carries no reset; validity is tracked purely by the level.
    always_ff @(posedge i_clk) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= i_wr_data;
    end

    assign o_rd_data      = mem_q[rd_ptr_q];
    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_level        = level_q;

`ifdef FIFO_SYNC_PROG_ERR_EN
    logic ovf_q, unf_q;

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (i_wr_en & full_q)
                ovf_q <= 1'b1;
            else if (i_err_clr)
                ovf_q <= 1'b0;
            if (i_rd_en & empty_q)
                unf_q <= 1'b1;
            else if (i_err_clr)
                unf_q <= 1'b0;
        end
    end

    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = i_err_clr;
    assign o_overflow     = 1'b0;
    assign o_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench for fifo_sync_prog at Depth=5, Width=8; error-flag expectations follow FIFO_SYNC_PROG_ERR_EN.
module tb_fifo_sync_prog;

    localparam int DEPTH = 5;
    localparam int WIDTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);
`ifdef FIFO_SYNC_PROG_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [LW-1:0]    afull_thr;
    logic [LW-1:0]    aempty_thr;
    logic             err_clr;
    logic [WIDTH-1:0] rd_data;
    logic             full, empty, afull, aempty;
    logic [LW-1:0]    level;
    logic             ovf, unf;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];

    fifo_sync_prog #(.Depth(DEPTH), .Width(WIDTH)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (wr_en),
        .i_wr_data      (wr_data),
        .i_rd_en        (rd_en),
        .i_afull_thr    (afull_thr),
        .i_aempty_thr   (aempty_thr),
        .i_err_clr      (err_clr),
        .o_rd_data      (rd_data),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (afull),
        .o_almost_empty (aempty),
        .o_level        (level),
        .o_overflow     (ovf),
        .o_underflow    (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic we, input logic [7:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        step();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; err_clr = 1'b0;
        afull_thr = LW'(4); aempty_thr = LW'(1);
        step();
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_aempty", 32'(aempty), 1);
        chk("rst_afull", 32'(afull), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_unf", 32'(unf), 0);
        rst = 1'b0;
        step();

        // Fill 0x11..0x55
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b1, 8'(k * 17), 1'b0);
            chk("fill_level", 32'(level), 32'(k));
            chk("fill_aempty", 32'(aempty), 32'(k <= 1));
            chk("fill_afull", 32'(afull), 32'(k >= 4));
            chk("fill_full", 32'(full), 32'(k == 5));
            chk("fill_head", 32'(rd_data), 32'h11);
        end

        // Write while full with a read: write dropped, read pops
        cyc(1'b1, 8'h66, 1'b1);
        chk("ovf_level", 32'(level), 4);
        chk("ovf_head", 32'(rd_data), 32'h22);
        chk("ovf_full", 32'(full), 0);
        chk("ovf_flag", 32'(ovf), 32'(ERR_EN));
        for (int k = 2; k <= 5; k++) begin
            chk("drain_head", 32'(rd_data), 32'(k * 17));
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_level", 32'(level), 0);
        chk("ovf_sticky", 32'(ovf), 32'(ERR_EN));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 0);

        // Interleaved wrap-around
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            chk("wrap_head", 32'(rd_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("wrap_empty", 32'(empty), 1);

        // Simultaneous write/read at level 2
        cyc(1'b1, 8'hA0, 1'b0);
        cyc(1'b1, 8'hA1, 1'b0);
        q.push_back(8'hA0);
        q.push_back(8'hA1);
        for (int k = 0; k < 10; k++) begin
            chk("sim_head", 32'(rd_data), 32'(q[0]));
            cyc(1'b1, 8'(8'hB0 + k), 1'b1);
            void'(q.pop_front());
            q.push_back(8'(8'hB0 + k));
            chk("sim_level", 32'(level), 2);
        end
        while (q.size() > 0) begin
            chk("sim_drain", 32'(rd_data), 32'(q[0]));
            cyc(1'b0, 8'h00, 1'b1);
            void'(q.pop_front());
        end
        chk("sim_empty", 32'(empty), 1);

        // Read while empty with a write
        cyc(1'b1, 8'hA5, 1'b1);
        chk("unf_level", 32'(level), 1);
        chk("unf_empty", 32'(empty), 0);
        chk("unf_head", 32'(rd_data), 32'hA5);
        chk("unf_flag", 32'(unf), 32'(ERR_EN));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("unf_clr", 32'(unf), 0);
        chk("unf_keep", 32'(level), 1);

        // Asynchronous reset with 3 entries
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        chk("pre_rst_level", 32'(level), 3);
        rst = 1'b1;
        #1;
        chk("arst_level", 32'(level), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full", 32'(full), 0);
        step();
        rst = 1'b0;
        cyc(1'b1, 8'h77, 1'b0);
        chk("post_rst_head", 32'(rd_data), 32'h77);
        chk("post_rst_level", 32'(level), 1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_empty", 32'(empty), 1);

        // Threshold edge cases
        afull_thr = LW'(0);
        #1;
        chk("thr0_before_edge", 32'(afull), 0);
        step();
        chk("thr0_afull", 32'(afull), 1);
        afull_thr = LW'(6);
        aempty_thr = LW'(5);
        for (int k = 1; k <= 5; k++)
            cyc(1'b1, 8'(k), 1'b0);
        chk("thr_full", 32'(full), 1);
        chk("thr6_afull", 32'(afull), 0);
        chk("thr5_aempty", 32'(aempty), 1);
        afull_thr = LW'(5);
        step();
        chk("thr5_afull", 32'(afull), 1);
        for (int k = 1; k <= 5; k++) begin
            chk("thr_drain", 32'(rd_data), 32'(k));
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("thr_empty", 32'(empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_sync_prog.md
# fifo_sync_prog

Single-clock FIFO with arbitrary (non-power-of-two) depth, an exact fill-level output and runtime-programmable almost-full/almost-empty thresholds. It is the general-purpose buffer for same-domain producer/consumer paths (stream staging, command queues, rate smoothing). Read data is show-ahead: the head entry is presented whenever the FIFO is non-empty. Optional sticky overflow/underflow error flags support debug.

## Interface
- `Depth`, 8: number of entries; any integer ≥ 2, not restricted to powers of two.
- `Width`, 8: data width in bits.
- Derived: `AW` = $clog2(Depth) (pointer width); `LW` = $clog2(Depth+1) (level width).

Ports:
- `i_clk`  in  1  clock; all logic samples on the rising edge.
- `i_rst`  in  1  asynchronous reset, active-high.
- `i_wr_en`  in  1  write request.
- `i_wr_data`  in  Width  write data.
- `i_rd_en`  in  1  read request; pops the head entry.
- `i_afull_thr`  in  LW  almost-full threshold.
- `i_aempty_thr`  in  LW  almost-empty threshold.
- `i_err_clr`  in  1  clears the sticky error flags.
- `o_rd_data`  out  Width  head entry, combinational from memory.
- `o_full`  out  1  level == Depth.
- `o_empty`  out  1  level == 0.
- `o_almost_full`  out  1  level ≥ i_afull_thr.
- `o_almost_empty`  out  1  level ≤ i_aempty_thr.
- `o_level`  out  LW  current entry count, 0..Depth.
- `o_overflow`  out  1  sticky: write attempted while full.
- `o_underflow`  out  1  sticky: read attempted while empty.

## Operation
- Write accept: `wr_acc = i_wr_en & ~o_full`. Read accept: `rd_acc = i_rd_en & ~o_empty`.
- A write while full is dropped: no memory or pointer change. A read while empty is ignored.
- There is no pass-through. A write while full is refused even if a read occurs in the same cycle. A read while empty is refused even if a write occurs in the same cycle.
- Write pointer and read pointer each count 0..Depth-1. After Depth-1 they wrap to 0 on the next accept; this is an explicit compare, not modulo-2^AW.
- Memory is written at `mem[wr_ptr]` on `wr_acc`. The memory is not reset.
- `o_level` next value:
  - +1 on `wr_acc` only;
  - −1 on `rd_acc` only;
  - unchanged when both or neither accept.
- Full and empty are derived only from the level, not from pointer comparison.
- `o_rd_data = mem[rd_ptr]`. It is valid only while `~o_empty`; when empty its value is don't-care.
- Thresholds are sampled every cycle. A threshold change takes effect on the almost flags at the next rising edge.
- Edge cases:
  - `i_afull_thr` = 0: almost-full is always true.
  - `i_aempty_thr` ≥ Depth: almost-empty is always true.
  - `i_afull_thr` > Depth: almost-full is never true.

## Timing
- All status outputs (`o_full`, `o_empty`, `o_almost_*`, `o_level`, error flags) are registers. They are computed from next-state level/thresholds and update on the same edge as the accepting request.
- Reset values (asynchronous, immediate on `i_rst` = 1):
  - level 0, pointers 0, `o_empty` = 1, `o_full` = 0;
  - `o_almost_empty` = 1, `o_almost_full` = 0;
  - `o_overflow` = 0, `o_underflow` = 0.
- After reset release, the almost flags reflect the thresholds from the first rising edge onward.
- Write-to-read latency: 1 cycle. Data written at edge N appears on `o_rd_data` with `o_empty` = 0 after edge N.
- Read: `o_rd_data` shows the next entry immediately after the popping edge.
- Reset mid-operation: all contents are logically discarded; level returns to 0 regardless of pending requests.

## Configuration
- Macro `FIFO_SYNC_PROG_ERR_EN`.
- Defined:
  - `o_overflow` sets on `i_wr_en & o_full`;
  - `o_underflow` sets on `i_rd_en & o_empty`;
  - both are sticky until `i_err_clr`;
  - when a set and a clear occur in the same cycle, the set wins.
- Undefined: both flags are tied to 0, `i_err_clr` is ignored, and no error registers are inferred. The port list is identical either way.

## Test plan
- Depth=5, Width=8, thresholds afull=4, aempty=1. Reset, then write 0x11..0x55 on 5 consecutive cycles:
  - after each write, `o_level` = 1..5;
  - `o_almost_empty` drops after the 2nd write;
  - `o_almost_full` rises after the 4th write;
  - `o_full` = 1 after the 5th write.
- From full, write 0x66 with `i_rd_en` = 1 in the same cycle: the read pops 0x11, the write is dropped, `o_level` = 4. With the macro defined, `o_overflow` = 1.
- Wrap-around with Depth=5: run 12 interleaved writes 0x01..0x0C and reads. Reads return 0x01..0x0C in order; pointers wrap at index 4 → 0 twice.
- At level 2, assert simultaneous write and read for 10 cycles: `o_level` stays 2, and data order is preserved.
- From empty, read while writing 0xA5: the read is refused, `o_level` = 1, and `o_rd_data` = 0xA5 on the next cycle. With the macro defined, `o_underflow` = 1; `i_err_clr` clears it the next cycle.
- Assert `i_rst` with 3 entries stored: `o_level` = 0, `o_empty` = 1 immediately. After release, a write of 0x77 followed by a read returns 0x77.
